// File: rtl/ll_traverse_engine.sv
// ll_traverse_engine
// Walks a singly_linked_list from its head, issuing read ops and following
// next_node_addr. Each node's data is emitted on a valid/ready stream, with
// out_last set on the final node.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               begin traversal (sampled only in IDLE)
//   busy/done/error     status; done pulses once, error is valid with done
//   node_count          nodes emitted in current/last traversal
//   ll_*                read-op interface to singly_linked_list
//   out_valid/ready     node stream handshake; out_data/out_addr/out_last payload
//
// Optional build macro LL_TRAVERSE_PREFETCH_EN: adds a second holding
// register. The read for the next node is issued while a beat waits for
// out_ready, and the result is parked there.
module ll_traverse_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_NODE   = 8,
  localparam int ADDR_WIDTH = $clog2(MAX_NODE + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] node_count,
  output logic [2:0]            ll_op,
  output logic [ADDR_WIDTH-1:0] ll_addr,
  output logic                  ll_op_start,
  input  logic                  ll_op_done,
  input  logic                  ll_fault,
  input  logic [DATA_WIDTH-1:0] ll_data_out,
  input  logic [ADDR_WIDTH-1:0] ll_next_node_addr,
  input  logic [ADDR_WIDTH-1:0] ll_head,
  input  logic [ADDR_WIDTH-1:0] ll_length,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_last
);
  localparam logic [ADDR_WIDTH-1:0] ADDR_NULL = ADDR_WIDTH'(MAX_NODE + 1);
  localparam logic [ADDR_WIDTH-1:0] MAX_A     = ADDR_WIDTH'(MAX_NODE);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_EMIT, S_FINISH} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, len_q, len_d, cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, next_q, next_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d, err_q, err_d;

`ifdef LL_TRAVERSE_PREFETCH_EN
  logic                  pf_busy_q, pf_busy_d, pf_vld_q, pf_vld_d, pf_fault_q, pf_fault_d;
  logic [DATA_WIDTH-1:0] pf_data_q, pf_data_d;
  logic [ADDR_WIDTH-1:0] pf_next_q, pf_next_d;
  logic                  pf_hit, pf_fault_sel, pf_legal;
  logic [DATA_WIDTH-1:0] pf_data_sel;
  logic [ADDR_WIDTH-1:0] pf_next_sel;

  // A read landing on the same cycle as the handshake is consumed directly.
  assign pf_hit       = pf_vld_q || (pf_busy_q && ll_op_done);
  assign pf_fault_sel = pf_vld_q ? pf_fault_q : ll_fault;
  assign pf_data_sel  = pf_vld_q ? pf_data_q  : ll_data_out;
  assign pf_next_sel  = pf_vld_q ? pf_next_q  : ll_next_node_addr;
  assign pf_legal     = !last_q && (next_q < MAX_A) && (cnt_q < MAX_A);
  assign ll_op_start  = (state_q == S_ISSUE) || (state_q == S_WAIT) || pf_busy_q;
`else
  assign ll_op_start  = (state_q == S_ISSUE) || (state_q == S_WAIT);
`endif

  // The list qualifies op on op_start level, so addr is held with op_start.
  assign ll_addr    = ll_op_start ? ptr_q : ADDR_NULL;
  assign ll_op      = 3'd0;
  assign busy       = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_EMIT);
  assign done       = (state_q == S_FINISH);
  assign error      = err_q;
  assign node_count = cnt_q;
  assign out_valid  = (state_q == S_EMIT);
  assign out_data   = data_q;
  assign out_addr   = addr_q;
  assign out_last   = last_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    next_d  = next_q;
    data_d  = data_q;
    last_d  = last_q;
    err_d   = err_q;
`ifdef LL_TRAVERSE_PREFETCH_EN
    pf_busy_d  = pf_busy_q;
    pf_vld_d   = pf_vld_q;
    pf_fault_d = pf_fault_q;
    pf_data_d  = pf_data_q;
    pf_next_d  = pf_next_q;
`endif
    case (state_q)
      S_IDLE: if (start) begin
        len_d   = ll_length;
        ptr_d   = ll_head;
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = (ll_length == '0) ? S_FINISH : S_ISSUE;
`ifdef LL_TRAVERSE_PREFETCH_EN
        pf_busy_d = 1'b0;
        pf_vld_d  = 1'b0;
`endif
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: if (ll_op_done) begin
        if (ll_fault) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          data_d  = ll_data_out;
          next_d  = ll_next_node_addr;
          addr_d  = ptr_q;
          cnt_d   = cnt_q + 1'b1;
          last_d  = ((cnt_q + 1'b1) == len_q) || (ll_next_node_addr == ADDR_NULL);
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
`ifdef LL_TRAVERSE_PREFETCH_EN
        if (pf_busy_q && ll_op_done) begin
          pf_busy_d  = 1'b0;
          pf_vld_d   = 1'b1;
          pf_fault_d = ll_fault;
          pf_data_d  = ll_data_out;
          pf_next_d  = ll_next_node_addr;
        end
        if (!out_ready && !pf_busy_q && !pf_vld_q && pf_legal) begin
          ptr_d     = next_q;
          pf_busy_d = 1'b1;
        end
`endif
        if (out_ready) begin
          if (last_q) begin
            // Chain ended early (null before length reached) counts as error.
            err_d   = (cnt_q != len_q);
            state_d = S_FINISH;
          end else if ((next_q >= MAX_A) || (cnt_q >= MAX_A)) begin
            // Illegal pointer, or loop guard: never emit more than MAX_NODE beats.
            err_d   = 1'b1;
            state_d = S_FINISH;
          end
`ifdef LL_TRAVERSE_PREFETCH_EN
          else if (pf_hit) begin
            pf_busy_d = 1'b0;
            pf_vld_d  = 1'b0;
            if (pf_fault_sel) begin
              err_d   = 1'b1;
              state_d = S_FINISH;
            end else begin
              data_d = pf_data_sel;
              next_d = pf_next_sel;
              addr_d = ptr_q;
              cnt_d  = cnt_q + 1'b1;
              last_d = ((cnt_q + 1'b1) == len_q) || (pf_next_sel == ADDR_NULL);
            end
          end else if (pf_busy_q) begin
            // Read still in flight: WAIT takes over the held op_start.
            pf_busy_d = 1'b0;
            state_d   = S_WAIT;
          end
`endif
          else begin
            ptr_d   = next_q;
            state_d = S_ISSUE;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      next_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef LL_TRAVERSE_PREFETCH_EN
      pf_busy_q  <= 1'b0;
      pf_vld_q   <= 1'b0;
      pf_fault_q <= 1'b0;
      pf_data_q  <= '0;
      pf_next_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      next_q  <= next_d;
      data_q  <= data_d;
      last_q  <= last_d;
      err_q   <= err_d;
`ifdef LL_TRAVERSE_PREFETCH_EN
      pf_busy_q  <= pf_busy_d;
      pf_vld_q   <= pf_vld_d;
      pf_fault_q <= pf_fault_d;
      pf_data_q  <= pf_data_d;
      pf_next_q  <= pf_next_d;
`endif
    end
  end
endmodule

// File: tb/tb_ll_traverse_engine.sv
// Directed bench for ll_traverse_engine: a small list model answers reads,
// a table of traversal cases is applied in a loop, and reset-in-WAIT is
// exercised by hand.
module tb_ll_traverse_engine;
  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, error;
  logic [AW-1:0] node_count;
  logic [2:0]    ll_op;
  logic [AW-1:0] ll_addr;
  logic          ll_op_start;
  logic          ll_op_done = 1'b0;
  logic          ll_fault = 1'b0;
  logic [DW-1:0] ll_data_out = '0;
  logic [AW-1:0] ll_next_node_addr = '0;
  logic [AW-1:0] ll_head = '0;
  logic [AW-1:0] ll_length = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_last;

  ll_traverse_engine #(.DATA_WIDTH(DW), .MAX_NODE(8)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
    .node_count(node_count), .ll_op(ll_op), .ll_addr(ll_addr), .ll_op_start(ll_op_start),
    .ll_op_done(ll_op_done), .ll_fault(ll_fault), .ll_data_out(ll_data_out),
    .ll_next_node_addr(ll_next_node_addr), .ll_head(ll_head), .ll_length(ll_length),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // List contents: 2->0->5->NULL, 6->7->NULL, 3->12 (illegal), 1->1 (loop).
  logic [DW-1:0] mem_data [16];
  logic [AW-1:0] mem_next [16];
  int            fault_read = -1;
  int            rd_cnt;
  int            lat;

  // List model: op_done two cycles after op_start is seen, one-cycle pulse.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ll_op_done <= 1'b0;
      lat        <= 0;
      rd_cnt     <= 0;
    end else begin
      ll_op_done <= 1'b0;
      if (start) rd_cnt <= 0;
      if (ll_op_start && !ll_op_done) begin
        if (lat == 1) begin
          ll_op_done        <= 1'b1;
          ll_data_out       <= mem_data[ll_addr];
          ll_next_node_addr <= mem_next[ll_addr];
          ll_fault          <= (rd_cnt == fault_read);
          rd_cnt            <= rd_cnt + 1;
          lat               <= 0;
        end else lat <= lat + 1;
      end else lat <= 0;
    end
  end

  // Stream sink: drives out_ready, records beats, watches the stall window.
  logic [AW-1:0] b_addr [16];
  logic [DW-1:0] b_data [16];
  logic          b_last [16];
  int nb, stall_len = 0, stall_beat = -1, stall_left, stall_seen, stall_bad, stall_ops;
  logic [DW-1:0] stall_exp;

  always @(negedge clk) begin
    if (start) begin
      nb = 0; stall_left = stall_len; stall_seen = 0; stall_bad = 0; stall_ops = 0;
    end
    if (out_valid && nb == stall_beat && stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
      stall_seen++;
      if (out_data != stall_exp) stall_bad++;
      if (ll_op_start) stall_ops++;
    end else out_ready = 1'b1;
    if (out_valid && out_ready && nb < 16) begin
      b_addr[nb] = out_addr; b_data[nb] = out_data; b_last[nb] = out_last;
      nb++;
    end
  end

  int tests = 0, fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Expected beats packed little-endian: beat i is nibble i of eaddr,
  // byte i of edata, bit i of elast.
  typedef struct {
    string       name;
    logic [3:0]  len, head;
    int          fault_read, stall_beat, stall_len, nbeats;
    logic [31:0] eaddr;
    logic [63:0] edata;
    logic [7:0]  elast;
    logic        eerr;
    logic [3:0]  ecnt;
  } tc_t;

  tc_t tc [8];

  task automatic run_case(input tc_t t);
    int cyc;
    ll_length = t.len; ll_head = t.head; fault_read = t.fault_read;
    stall_beat = t.stall_beat; stall_len = t.stall_len;
    stall_exp = t.edata[8*(t.stall_beat < 0 ? 0 : t.stall_beat) +: 8];
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    while (!done && cyc < 300) begin @(posedge clk); #1; cyc++; end
    chk({t.name, " done_seen"}, int'(done), 1);
    if (t.len == 0) chk({t.name, " done_latency"}, cyc, 0);
    chk({t.name, " error"}, int'(error), int'(t.eerr));
    chk({t.name, " node_count"}, int'(node_count), int'(t.ecnt));
    chk({t.name, " busy_at_done"}, int'(busy), 0);
    @(posedge clk); #1;
    chk({t.name, " done_pulse"}, int'(done), 0);
    chk({t.name, " error_hold"}, int'(error), int'(t.eerr));
    chk({t.name, " nbeats"}, nb, t.nbeats);
    for (int i = 0; i < t.nbeats && i < nb; i++) begin
      chk($sformatf("%s beat%0d addr", t.name, i), int'(b_addr[i]), int'(t.eaddr[4*i +: 4]));
      chk($sformatf("%s beat%0d data", t.name, i), int'(b_data[i]), int'(t.edata[8*i +: 8]));
      chk($sformatf("%s beat%0d last", t.name, i), int'(b_last[i]), int'(t.elast[i]));
    end
    if (t.stall_len > 0) begin
      chk({t.name, " stall_cycles"}, stall_seen, t.stall_len);
      chk({t.name, " stall_data_stable"}, stall_bad, 0);
      chk({t.name, " stall_no_op_start"}, stall_ops, 0);
    end
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 16; i++) begin mem_data[i] = 8'h00; mem_next[i] = 4'd9; end
    mem_data[2] = 8'hA1; mem_next[2] = 4'd0;
    mem_data[0] = 8'hB2; mem_next[0] = 4'd5;
    mem_data[5] = 8'hC3; mem_next[5] = 4'd9;
    mem_data[6] = 8'hD4; mem_next[6] = 4'd7;
    mem_data[7] = 8'hE5; mem_next[7] = 4'd9;
    mem_data[3] = 8'h33; mem_next[3] = 4'd12;
    mem_data[1] = 8'h11; mem_next[1] = 4'd1;

    //        name       len   head  fault stbt stlen nb  eaddr         edata                    elast         err   cnt
    tc[0] = '{"empty",   4'd0, 4'd2, -1,   -1,  0,    0,  32'h0,        64'h0,                   8'b0,         1'b0, 4'd0};
    tc[1] = '{"three",   4'd3, 4'd2, -1,   -1,  0,    3,  32'h502,      64'hC3B2A1,              8'b100,       1'b0, 4'd3};
    tc[2] = '{"stall",   4'd3, 4'd2, -1,   1,   4,    3,  32'h502,      64'hC3B2A1,              8'b100,       1'b0, 4'd3};
    tc[3] = '{"fault",   4'd3, 4'd2, 1,    -1,  0,    1,  32'h2,        64'hA1,                  8'b0,         1'b1, 4'd1};
    tc[4] = '{"short",   4'd4, 4'd6, -1,   -1,  0,    2,  32'h76,       64'hE5D4,                8'b10,        1'b1, 4'd2};
    tc[5] = '{"illegal", 4'd3, 4'd3, -1,   -1,  0,    1,  32'h3,        64'h33,                  8'b0,         1'b1, 4'd1};
    tc[6] = '{"loop",    4'd15,4'd1, -1,   -1,  0,    8,  32'h11111111, 64'h1111111111111111,    8'b0,         1'b1, 4'd8};
    tc[7] = '{"lenstop", 4'd2, 4'd2, -1,   -1,  0,    2,  32'h02,       64'hB2A1,                8'b10,        1'b0, 4'd2};

    // Reset state
    #2;
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst error", int'(error), 0);
    chk("rst node_count", int'(node_count), 0);
    chk("rst ll_addr", int'(ll_addr), 9);
    chk("rst ll_op_start", int'(ll_op_start), 0);
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst out_data", int'(out_data), 0);
    chk("rst ll_op", int'(ll_op), 0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 8; i++) run_case(tc[i]);

    // Reset asserted while a read is outstanding in WAIT.
    ll_length = 4'd3; ll_head = 4'd2; fault_read = -1; stall_beat = -1; stall_len = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;   // now in ISSUE
    @(posedge clk); #1;                // now in WAIT
    chk("rstwait op_start_before", int'(ll_op_start), 1);
    rst = 1'b1;
    #1;
    chk("rstwait ll_op_start", int'(ll_op_start), 0);
    chk("rstwait busy", int'(busy), 0);
    chk("rstwait out_valid", int'(out_valid), 0);
    chk("rstwait ll_addr", int'(ll_addr), 9);
    @(posedge clk); #1 rst = 1'b0;
    cyc = 0;
    run_case(tc[1]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
